stack_ctrl: RTL

// Stack sequencer for the 8-bit pipelined CPU. Owns the stack pointer (SP) and runs PUSH, POP,

---
 rtl/stack_ctrl_if.sv | 40 ++++
 rtl/stack_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_if.sv
// Bus bundle between the stack sequencer and its requesters / unified memory port.
// The slave modport is the stack_ctrl view; master is the environment driving it.
interface stack_ctrl_if;
    logic       push_req;
    logic [7:0] push_data;
    logic       pop_req;
    logic       int_req;
    logic       rti_req;
    logic [7:0] pc_in;
    logic [3:0] flags_in;
    logic [7:0] fetch_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       fetch_grant;
    logic       busy;
    logic       done;
    logic [7:0] pop_data;
    logic       pc_load;
    logic [7:0] new_pc;
    logic [3:0] flags_out;
    logic [7:0] sp;
    logic       ovf;
    logic       unf;

    modport slave (
        input  push_req, push_data, pop_req, int_req, rti_req,
               pc_in, flags_in, fetch_addr, mem_rdata,
        output mem_addr, mem_wdata, mem_we, fetch_grant, busy, done,
               pop_data, pc_load, new_pc, flags_out, sp, ovf, unf
    );

    modport master (
        output push_req, push_data, pop_req, int_req, rti_req,
               pc_in, flags_in, fetch_addr, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, fetch_grant, busy, done,
               pop_data, pc_load, new_pc, flags_out, sp, ovf, unf
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: owns SP, runs PUSH/POP/interrupt entry/RTI and arbitrates
// the single memory port between those sequences and instruction fetch.
module stack_ctrl #(
    parameter logic [7:0] SP_INIT      = 8'hFF,
    parameter logic [7:0] SP_LIMIT     = 8'h80,
    parameter logic [7:0] INT_VEC_ADDR = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, PUSH, POP_RD, POP_WB,
        INT_PC, INT_FL, INT_VEC, INT_LD,
        RTI_FL, RTI_PC, RTI_LD
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] sp_q, sp_nxt;
    logic       rd_unf_q, rd_unf_nxt;
    logic       done_q, done_nxt;
    logic       pc_load_q, pc_load_nxt;
    logic       ovf_q, unf_q, ovf_set, unf_set;
    logic [7:0] pop_data_q, new_pc_q;
    logic [3:0] flags_q;
    logic       cap_pop, cap_fl, cap_pc;
    logic       wr_req, rd_req;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we, fetch_grant;
    logic [7:0] rd_data;

    logic       sp_full, sp_empty;
    logic [7:0] sp_inc, sp_dec;

    assign sp_full  = (sp_q < SP_LIMIT);
    assign sp_empty = (sp_q == SP_INIT);
    assign sp_inc   = sp_q + 8'd1;
    assign sp_dec   = sp_q - 8'd1;
    // A read issued on an empty stack returns zero instead of stale memory.
    assign rd_data  = rd_unf_q ? 8'h00 : bus.mem_rdata;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        sp_nxt      = sp_q;
        rd_unf_nxt  = rd_unf_q;
        done_nxt    = 1'b0;
        pc_load_nxt = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        cap_pop     = 1'b0;
        cap_fl      = 1'b0;
        cap_pc      = 1'b0;
        wr_req      = 1'b0;
        rd_req      = 1'b0;
        mem_addr    = sp_q;
        mem_wdata   = 8'h00;
        mem_we      = 1'b0;
        fetch_grant = 1'b0;

        case (state)
            IDLE: begin
                mem_addr    = bus.fetch_addr;
                fetch_grant = 1'b1;
                if (!done_q) begin
                    if (bus.int_req)       state_nxt = INT_PC;
                    else if (bus.rti_req)  state_nxt = RTI_FL;
                    else if (bus.push_req) state_nxt = PUSH;
                    else if (bus.pop_req)  state_nxt = POP_RD;
                end
            end
            PUSH: begin
                mem_wdata = bus.push_data;
                wr_req    = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            POP_RD: begin
                rd_req    = 1'b1;
                state_nxt = POP_WB;
            end
            POP_WB: begin
                cap_pop   = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            INT_PC: begin
                mem_wdata = bus.pc_in;
                wr_req    = 1'b1;
                state_nxt = INT_FL;
            end
            INT_FL: begin
                mem_wdata = {4'b0000, bus.flags_in};
                wr_req    = 1'b1;
                state_nxt = INT_VEC;
            end
            INT_VEC: begin
                mem_addr   = INT_VEC_ADDR;
                rd_unf_nxt = 1'b0;
                state_nxt  = INT_LD;
            end
            INT_LD, RTI_LD: begin
                cap_pc      = 1'b1;
                done_nxt    = 1'b1;
                pc_load_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            RTI_FL: begin
                rd_req    = 1'b1;
                state_nxt = RTI_PC;
            end
            RTI_PC: begin
                cap_fl    = 1'b1;
                rd_req    = 1'b1;
                state_nxt = RTI_LD;
            end
            default: state_nxt = IDLE;
        endcase

        // Limit checks shared by every stack write and every stack read.
        if (wr_req) begin
            if (sp_full) begin
                ovf_set = 1'b1;
            end else begin
                mem_we = 1'b1;
                sp_nxt = sp_dec;
            end
        end
        if (rd_req) begin
            mem_addr = sp_inc;
            if (sp_empty) begin
                unf_set    = 1'b1;
                rd_unf_nxt = 1'b1;
            end else begin
                sp_nxt     = sp_inc;
                rd_unf_nxt = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sp_q       <= SP_INIT;
            rd_unf_q   <= 1'b0;
            done_q     <= 1'b0;
            pc_load_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pop_data_q <= 8'h00;
            new_pc_q   <= 8'h00;
            flags_q    <= 4'h0;
        end else begin
            state     <= state_nxt;
            sp_q      <= sp_nxt;
            rd_unf_q  <= rd_unf_nxt;
            done_q    <= done_nxt;
            pc_load_q <= pc_load_nxt;
            if (ovf_set) ovf_q      <= 1'b1;
            if (unf_set) unf_q      <= 1'b1;
            if (cap_pop) pop_data_q <= rd_data;
            if (cap_pc)  new_pc_q   <= rd_data;
            if (cap_fl)  flags_q    <= rd_data[3:0];
        end
    end

    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.mem_we      = mem_we;
    assign bus.fetch_grant = fetch_grant;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pop_data    = pop_data_q;
    assign bus.new_pc      = new_pc_q;
    assign bus.flags_out   = flags_q;
    assign bus.sp          = sp_q;
    assign bus.ovf         = ovf_q;
    assign bus.unf         = unf_q;

endmodule
